// File: rtl/weight_config_streamer_pkg.sv
// Shared types, header field layout and header legality check for the
// weight-configuration streamer.
package weight_cfg_pkg;

    typedef enum logic [1:0] {IDLE, PAYLOAD, DRAIN} state_t;

    localparam int LAYER_MSB  = 31;
    localparam int LAYER_LSB  = 24;
    localparam int NEURON_MSB = 23;
    localparam int NEURON_LSB = 12;
    localparam int COUNT_MSB  = 11;
    localparam int COUNT_LSB  = 0;

    function automatic logic hdr_legal(input logic [31:0] word, input int num_layers,
                                       input int max_neurons, input int max_weights);
        int l, n, c;
        l = int'(word[LAYER_MSB:LAYER_LSB]);
        n = int'(word[NEURON_MSB:NEURON_LSB]);
        c = int'(word[COUNT_MSB:COUNT_LSB]);
        return (l < num_layers) && (n < max_neurons) && (c != 0) && (c <= max_weights);
    endfunction

endpackage

// File: rtl/weight_config_streamer_if.sv
// Host word stream (valid/ready) feeding the weight-configuration streamer.
interface weight_config_streamer_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/weight_config_streamer.sv
// Turns a header + N payload host words into broadcast weight writes
// addressed to one (layer, neuron) weight memory; illegal headers are drained.
module weight_config_streamer
    import weight_cfg_pkg::*;
#(
    parameter int data_bits   = 16,
    parameter int max_weights = 784,
    parameter int num_layers  = 4,
    parameter int max_neurons = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            abort,
    weight_config_streamer_if.slave         host,
    output logic                            weight_valid,
    output logic [31:0]                     weight_value,
    output logic [31:0]                     config_layer_no,
    output logic [31:0]                     config_neuron_no,
    output logic                            busy,
    output logic                            done,
    output logic                            hdr_error
);

    // DRAIN must be able to count any 12-bit header count, even above max_weights.
    localparam int CW = ($clog2(max_weights + 1) > 12) ? $clog2(max_weights + 1) : 12;

    state_t                r_state, w_state_nxt;
    logic [CW-1:0]         r_remaining, w_remaining_nxt;
    logic                  r_weight_valid, r_done, r_hdr_error;
    logic [31:0]           r_weight_value, r_layer, r_neuron;
    logic                  w_accept, w_emit, w_done, w_hdr_err, w_cfg_load, w_last;
    logic [11:0]           w_count;
    logic signed [data_bits-1:0] w_weight;

    assign host.s_ready = !reset && !abort;
    assign w_accept     = host.s_valid && host.s_ready;
    assign w_count      = host.s_data[COUNT_MSB:COUNT_LSB];
    assign w_weight     = host.s_data[data_bits-1:0];
    assign w_last       = (r_remaining == CW'(1));

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_emit          = 1'b0;
        w_done          = 1'b0;
        w_hdr_err       = 1'b0;
        w_cfg_load      = 1'b0;
        if (abort) begin
            w_state_nxt     = IDLE;
            w_remaining_nxt = '0;
        end else if (w_accept) begin
            case (r_state)
                IDLE: begin
                    if (w_count == 12'd0) begin
                        w_hdr_err = 1'b1;
                    end else if (hdr_legal(host.s_data, num_layers, max_neurons, max_weights)) begin
                        w_cfg_load      = 1'b1;
                        w_remaining_nxt = CW'(w_count);
                        w_state_nxt     = PAYLOAD;
                    end else begin
                        w_hdr_err       = 1'b1;
                        w_remaining_nxt = CW'(w_count);
                        w_state_nxt     = DRAIN;
                    end
                end
                PAYLOAD: begin
                    w_emit          = 1'b1;
                    w_done          = w_last;
                    w_remaining_nxt = r_remaining - CW'(1);
                    if (w_last) w_state_nxt = IDLE;
                end
                DRAIN: begin
                    w_remaining_nxt = r_remaining - CW'(1);
                    if (w_last) w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_remaining    <= '0;
            r_weight_valid <= 1'b0;
            r_weight_value <= '0;
            r_layer        <= '0;
            r_neuron       <= '0;
            r_done         <= 1'b0;
            r_hdr_error    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_remaining    <= w_remaining_nxt;
            r_weight_valid <= w_emit;
            r_done         <= w_done;
            r_hdr_error    <= w_hdr_err;
            if (w_emit) r_weight_value <= 32'(w_weight);
            // Address only moves on a legal header so receivers never see it change mid-transfer.
            if (w_cfg_load) begin
                r_layer  <= 32'(host.s_data[LAYER_MSB:LAYER_LSB]);
                r_neuron <= 32'(host.s_data[NEURON_MSB:NEURON_LSB]);
            end
        end
    end

    assign weight_valid     = r_weight_valid;
    assign weight_value     = r_weight_value;
    assign config_layer_no  = r_layer;
    assign config_neuron_no = r_neuron;
    assign done             = r_done;
    assign hdr_error        = r_hdr_error;
    assign busy             = (r_state != IDLE);

endmodule

// File: tb/tb_weight_config_streamer.sv
// Scoreboard bench: expected writes are queued as payload words are accepted
// and checked (value, address, done, latency) when weight_valid appears.
module tb_weight_config_streamer;

    logic clk = 1'b0;
    logic reset, abort;
    always #5 clk = ~clk;

    weight_config_streamer_if hif();
    logic        weight_valid, busy, done, hdr_error;
    logic [31:0] weight_value, config_layer_no, config_neuron_no;

    weight_config_streamer dut (
        .clk              (clk),
        .reset            (reset),
        .abort            (abort),
        .host             (hif.slave),
        .weight_valid     (weight_valid),
        .weight_value     (weight_value),
        .config_layer_no  (config_layer_no),
        .config_neuron_no (config_neuron_no),
        .busy             (busy),
        .done             (done),
        .hdr_error        (hdr_error)
    );

    typedef struct {
        logic [31:0] v;
        logic [31:0] l;
        logic [31:0] n;
        logic        d;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int n_cmp = 0, n_err = 0;
    int cyc = 0, n_wv = 0, n_done = 0, n_herr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sext16(input logic [31:0] w);
        return {{16{w[15]}}, w[15:0]};
    endfunction

    function automatic logic [31:0] hdr(input int l, input int n, input int c);
        logic [31:0] h;
        h[31:24] = l[7:0];
        h[23:12] = n[11:0];
        h[11:0]  = c[11:0];
        return h;
    endfunction

    always @(negedge clk) begin
        if (weight_valid) begin
            exp_t e;
            n_wv++;
            if (sbq.size() == 0) chk("spurious_wv", 1, 0);
            else begin
                e = sbq.pop_front();
                chk("wv_value",   weight_value,     e.v);
                chk("wv_layer",   config_layer_no,  e.l);
                chk("wv_neuron",  config_neuron_no, e.n);
                chk("wv_done",    done,             e.d);
                chk("wv_latency", cyc,              e.cyc);
            end
        end else if (done) chk("done_without_wv", 1, 0);
        if (done)      n_done++;
        if (hdr_error) n_herr++;
    end

    task automatic drive(input logic [31:0] w, output bit acc);
        @(negedge clk);
        hif.s_valid = 1'b1;
        hif.s_data  = w;
        #1 acc = hif.s_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            hif.s_valid = 1'b0;
        end
    endtask

    task automatic pay(input logic [31:0] w, input int l, input int n, input bit last);
        bit acc;
        drive(w, acc);
        if (acc) sbq.push_back('{sext16(w), 32'(l), 32'(n), last, cyc});
    endtask

    task automatic xfer(input int l, input int n, input int c, input int gap);
        bit acc;
        int d0;
        d0 = n_done;
        drive(hdr(l, n, c), acc);
        for (int i = 0; i < c; i++) begin
            pay($urandom, l, n, i == c - 1);
            if (gap > 0) idle(gap);
        end
        idle(2);
        chk("xfer_sb_empty", sbq.size(), 0);
        chk("xfer_done_cnt", n_done - d0, 1);
        chk("xfer_idle", busy, 0);
        chk("xfer_layer_hold", config_layer_no, l);
        chk("xfer_neuron_hold", config_neuron_no, n);
    endtask

    initial begin
        bit acc;
        int wv0, d0, h0;
        logic [31:0] l_snap, n_snap;
        reset = 1'b1; abort = 1'b0; hif.s_valid = 1'b0; hif.s_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sready", hif.s_ready, 0);
        chk("rst_wv", weight_valid, 0);
        chk("rst_value", weight_value, 0);
        chk("rst_layer", config_layer_no, 0);
        chk("rst_neuron", config_neuron_no, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {done, hdr_error}, 0);
        @(negedge clk) reset = 1'b0;
        #1 chk("sready_idle", hif.s_ready, 1);

        // 1: back-to-back payload with sign extension
        d0 = n_done;
        drive(hdr(1, 5, 3), acc);
        pay(32'h0001, 1, 5, 0);
        pay(32'hFFFE, 1, 5, 0);
        pay(32'h7FFF, 1, 5, 1);
        idle(2);
        chk("t1_sb_empty", sbq.size(), 0);
        chk("t1_done", n_done - d0, 1);
        chk("t1_busy", busy, 0);

        // 2: gapped payload; address sampled at each write and held afterwards
        xfer(1, 5, 3, 2);
        xfer(3, 31, 5, 1);

        // 3: illegal layer, drained without bus writes
        wv0 = n_wv; h0 = n_herr;
        drive(hdr(7, 0, 2), acc);
        chk("t3_hdr_err", hdr_error, 1);
        chk("t3_busy", busy, 1);
        drive(32'h1234, acc);
        chk("t3_busy_mid", busy, 1);
        drive(32'h5678, acc);
        chk("t3_idle", busy, 0);
        idle(2);
        chk("t3_no_wv", n_wv - wv0, 0);
        chk("t3_herr_cnt", n_herr - h0, 1);
        xfer(0, 1, 2, 0);

        // illegal neuron
        drive(hdr(0, 32, 1), acc);
        chk("nrn_hdr_err", hdr_error, 1);
        drive(32'hAAAA, acc);
        idle(1);
        chk("nrn_idle", busy, 0);

        // 4: count 0 stays idle; count 785 drains
        drive(hdr(1, 1, 0), acc);
        chk("c0_hdr_err", hdr_error, 1);
        chk("c0_idle", busy, 0);
        wv0 = n_wv;
        drive(hdr(1, 1, 785), acc);
        chk("c785_hdr_err", hdr_error, 1);
        for (int i = 0; i < 784; i++) drive($urandom, acc);
        chk("c785_busy_before_last", busy, 1);
        drive($urandom, acc);
        chk("c785_idle", busy, 0);
        idle(2);
        chk("c785_no_wv", n_wv - wv0, 0);

        // 5: abort after 100 accepted words of a 784-word transfer
        wv0 = n_wv; d0 = n_done;
        drive(hdr(2, 7, 784), acc);
        for (int i = 0; i < 100; i++) pay($urandom, 2, 7, 0);
        @(negedge clk);
        abort = 1'b1;
        hif.s_data = 32'h4242;
        #1 chk("abort_sready", hif.s_ready, 0);
        @(posedge clk);
        #1 chk("abort_idle", busy, 0);
        @(negedge clk);
        abort = 1'b0;
        hif.s_valid = 1'b0;
        idle(2);
        chk("abort_wv_cnt", n_wv - wv0, 100);
        chk("abort_no_done", n_done - d0, 0);
        chk("abort_sb_empty", sbq.size(), 0);
        xfer(2, 8, 4, 0);

        // 6: reset mid-payload
        drive(hdr(3, 0, 10), acc);
        pay($urandom, 3, 0, 0);
        pay($urandom, 3, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        #1 chk("rst2_sready", hif.s_ready, 0);
        @(posedge clk);
        #1;
        chk("rst2_wv", weight_valid, 0);
        chk("rst2_value", weight_value, 0);
        chk("rst2_addr", {config_layer_no, config_neuron_no}, 0);
        chk("rst2_flags", {busy, done, hdr_error}, 0);
        @(negedge clk);
        reset = 1'b0;
        hif.s_valid = 1'b0;
        idle(1);
        chk("rst2_sb_empty", sbq.size(), 0);
        l_snap = 32'd3; n_snap = 32'd0;
        xfer(l_snap, n_snap, 10, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
